// File: rtl/mem_dump_tx_pkg.sv
// mem_dump_tx_pkg: word/byte geometry and FSM states shared by the dump transmitter and the loader.
package mem_dump_tx_pkg;
  localparam int NB_DATA        = 32;
  localparam int N_BITS         = 8;
  localparam int NB_ADDR        = 7;
  localparam int BYTES_PER_WORD = NB_DATA / N_BITS;
  localparam int NB_IDX         = $clog2(BYTES_PER_WORD);
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LATCH,
    ST_SEND,
    ST_WAIT,
    ST_FINISH
  } state_t;
endpackage

// File: rtl/mem_dump_tx_if.sv
// mem_dump_tx_if: debug-unit control, storage read port and tx_uart handshake of the dump transmitter.
interface mem_dump_tx_if;
  import mem_dump_tx_pkg::*;
  logic               start_i;
  logic [NB_ADDR-1:0] n_words_i;
  logic               rd_en_o;
  logic [NB_ADDR-1:0] rd_addr_o;
  logic [NB_DATA-1:0] rd_data_i;
  logic               tx_start_o;
  logic [N_BITS-1:0]  tx_data_o;
  logic               tx_done_tick_i;
  logic               busy_o;
  logic               done_o;
  modport master (
    input  start_i, n_words_i, rd_data_i, tx_done_tick_i,
    output rd_en_o, rd_addr_o, tx_start_o, tx_data_o, busy_o, done_o
  );
  modport slave (
    output start_i, n_words_i, rd_data_i, tx_done_tick_i,
    input  rd_en_o, rd_addr_o, tx_start_o, tx_data_o, busy_o, done_o
  );
endinterface

// File: rtl/mem_dump_tx_word_shift_out.sv
// word_shift_out: loads a storage word and shifts it out LSB byte first, flagging the last byte.
module word_shift_out
  import mem_dump_tx_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load_i,
  input  logic               shift_i,
  input  logic [NB_DATA-1:0] data_i,
  output logic [N_BITS-1:0]  byte_o,
  output logic               last_o
);
  logic [NB_DATA-1:0] word_q, word_d;
  logic [NB_IDX-1:0]  idx_q, idx_d;
  always_comb begin
    word_d = load_i ? data_i : shift_i ? word_q >> N_BITS : word_q;
    idx_d  = load_i ? '0 : shift_i ? idx_q + 1'b1 : idx_q;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end
  assign byte_o = word_q[N_BITS-1:0];
  assign last_o = idx_q == NB_IDX'(BYTES_PER_WORD - 1);
endmodule

// File: rtl/mem_dump_tx.sv
// mem_dump_tx: reads words 0..n_words-1 from storage and streams them byte-wise to tx_uart.
module mem_dump_tx
  import mem_dump_tx_pkg::*;
(
  input logic           clock,
  input logic           reset,
  mem_dump_tx_if.master bus
);
  state_t             state_q;
  logic [NB_ADDR-1:0] addr_q, n_q;
  logic               rd_en_q, tx_start_q, busy_q, done_q, last;
  logic [N_BITS-1:0]  tx_byte;
  word_shift_out u_shift (
    .clock  (clock),
    .reset  (reset),
    .load_i (state_q == ST_LATCH),
    .shift_i(state_q == ST_WAIT && bus.tx_done_tick_i && !last),
    .data_i (bus.rd_data_i),
    .byte_o (tx_byte),
    .last_o (last)
  );
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      n_q        <= '0;
      rd_en_q    <= 1'b0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.start_i) begin
          if (bus.n_words_i != '0) begin
            n_q     <= bus.n_words_i;
            addr_q  <= '0;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_READ;
          end else begin
            done_q  <= 1'b1;
            state_q <= ST_FINISH;
          end
        end
        ST_READ: begin
          rd_en_q <= 1'b0;
          state_q <= ST_LATCH;
        end
        ST_LATCH: begin
          tx_start_q <= 1'b1;
          state_q    <= ST_SEND;
        end
        ST_SEND: begin
          tx_start_q <= 1'b0;
          state_q    <= ST_WAIT;
        end
        // a stalled tx_uart simply keeps us here; the address stops at n_words-1 so it never wraps
        ST_WAIT: if (bus.tx_done_tick_i) begin
          if (!last) begin
            tx_start_q <= 1'b1;
            state_q    <= ST_SEND;
          end else if (addr_q == n_q - 1'b1) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_FINISH;
          end else begin
            addr_q  <= addr_q + 1'b1;
            rd_en_q <= 1'b1;
            state_q <= ST_READ;
          end
        end
        ST_FINISH: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign bus.rd_en_o    = rd_en_q;
  assign bus.rd_addr_o  = addr_q;
  assign bus.tx_start_o = tx_start_q;
  assign bus.tx_data_o  = tx_byte;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
endmodule

// File: tb/tb_mem_dump_tx.sv
// tb_mem_dump_tx: storage and tx_uart models around mem_dump_tx with a queue scoreboard on bytes and read addresses.
module tb_mem_dump_tx;
  import mem_dump_tx_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;
  mem_dump_tx_if bus ();
  mem_dump_tx dut (.clock(clock), .reset(reset), .bus(bus));
  logic        start = 1'b0;
  logic [6:0]  n_words = '0;
  logic [31:0] rd_data = '0;
  logic        tick = 1'b0;
  bit          stall = 1'b0;
  assign bus.start_i        = start;
  assign bus.n_words_i      = n_words;
  assign bus.rd_data_i      = rd_data;
  assign bus.tx_done_tick_i = tick;
  logic [31:0] mem [128];
  logic [7:0]  exp_q [$];
  logic [6:0]  addr_q [$];
  int cyc = 0, n_tx = 0, n_rd = 0, done_cnt = 0, mon_bytes = 0;
  int tx_cnt = 0, tick_edge = 0, start_edge = 0;
  int chk_cnt = 0, pass_cnt = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask
  task automatic fail(input string name);
    chk_cnt++;
    $display("FAIL %s: got an event, expected none", name);
  endtask
  always @(posedge clock) cyc <= cyc + 1;
  // storage: data appears one cycle after rd_en, junk otherwise
  always @(posedge clock) rd_data <= bus.rd_en_o ? mem[bus.rd_addr_o] : 32'hDEADBEEF;
  // tx_uart: one-cycle done tick ten cycles after each tx_start unless stalled
  always @(negedge clock) begin
    tick = 1'b0;
    if (bus.tx_start_o) tx_cnt = 10;
    else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0 && !stall) begin
        tick = 1'b1;
        tick_edge = cyc + 1;
      end
    end
  end
  // monitor: latencies are expressed as the spec cycle number (cyc + 1)
  always @(negedge clock) begin
    if (bus.rd_en_o) begin
      n_rd++;
      if (addr_q.size() == 0) fail("rd_extra");
      else check("rd_addr", 32'(bus.rd_addr_o), 32'(addr_q.pop_front()));
    end
    if (bus.tx_start_o) begin
      n_tx++;
      if (exp_q.size() == 0) fail("tx_extra");
      else check("tx_byte", 32'(bus.tx_data_o), 32'(exp_q.pop_front()));
      check("tx_lat", cyc + 1, mon_bytes == 0 ? start_edge + 3 :
                               (mon_bytes % 4 != 0) ? tick_edge + 1 : tick_edge + 3);
      check("busy_tx", 32'(bus.busy_o), 1);
      mon_bytes++;
    end
    if (bus.done_o) begin
      done_cnt++;
      mon_bytes = 0;
      check("busy_done", 32'(bus.busy_o), 0);
    end
    if (!reset) mon_bytes = 0;
  end
  task automatic push_word(input logic [31:0] w, input logic [6:0] a);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
    addr_q.push_back(a);
  endtask
  task automatic run(input logic [6:0] n);
    @(negedge clock);
    start = 1'b1;
    n_words = n;
    start_edge = cyc + 1;
    @(negedge clock);
    start = 1'b0;
  endtask
  task automatic wait_done(input int limit);
    int d0 = done_cnt;
    int i = 0;
    while (done_cnt == d0 && i < limit) begin
      @(negedge clock);
      i++;
    end
    if (done_cnt == d0) fail("done_timeout");
    repeat (2) @(negedge clock);
  endtask
  task automatic wait_tx(input int target, input int limit);
    int i = 0;
    while (n_tx < target && i < limit) begin
      @(negedge clock);
      i++;
    end
    if (n_tx < target) fail("tx_timeout");
  endtask
  task automatic tally(input string name, input int b0, input int d0, input int nb);
    check({name, "_bytes"}, n_tx - b0, nb);
    check({name, "_done"}, done_cnt - d0, 1);
    check({name, "_exp_left"}, exp_q.size(), 0);
    check({name, "_addr_left"}, addr_q.size(), 0);
    check({name, "_busy_after"}, 32'(bus.busy_o), 0);
  endtask
  task automatic check_idle(input string name);
    check({name, "_rd_en"}, 32'(bus.rd_en_o), 0);
    check({name, "_rd_addr"}, 32'(bus.rd_addr_o), 0);
    check({name, "_tx_start"}, 32'(bus.tx_start_o), 0);
    check({name, "_tx_data"}, 32'(bus.tx_data_o), 0);
    check({name, "_busy"}, 32'(bus.busy_o), 0);
    check({name, "_done"}, 32'(bus.done_o), 0);
  endtask
  initial begin
    int b0, d0, r0;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    repeat (3) @(negedge clock);
    check_idle("reset");
    reset = 1'b1;
    // single word
    mem[0] = 32'hA1B2C3D4;
    push_word(32'hA1B2C3D4, 7'd0);
    b0 = n_tx; d0 = done_cnt;
    run(7'd1);
    wait_done(500);
    tally("single", b0, d0, 4);
    // three words, byte stream 01,00,00,00,78,56,34,12,FF,FF,FF,FF
    mem[0] = 32'h00000001; mem[1] = 32'h12345678; mem[2] = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) push_word(mem[i], 7'(i));
    b0 = n_tx; d0 = done_cnt;
    run(7'd3);
    wait_done(1000);
    tally("three", b0, d0, 12);
    // zero words: done right after the start edge, nothing read or sent
    b0 = n_tx; d0 = done_cnt; r0 = n_rd;
    run(7'd0);
    check("zero_done_lat", 32'(bus.done_o), 1);
    repeat (3) @(negedge clock);
    check("zero_done_cnt", done_cnt - d0, 1);
    check("zero_rd", n_rd - r0, 0);
    check("zero_tx", n_tx - b0, 0);
    // restart while busy is ignored
    mem[0] = 32'hCAFEF00D; mem[1] = 32'h0BADBEEF;
    push_word(32'hCAFEF00D, 7'd0);
    push_word(32'h0BADBEEF, 7'd1);
    b0 = n_tx; d0 = done_cnt;
    run(7'd2);
    wait_tx(b0 + 1, 100);
    @(negedge clock);
    start = 1'b1; n_words = 7'd5;
    @(negedge clock);
    start = 1'b0;
    wait_done(1000);
    tally("restart", b0, d0, 8);
    // reset while waiting on the second byte
    mem[0] = 32'h11223344;
    push_word(32'h11223344, 7'd0);
    b0 = n_tx; d0 = done_cnt;
    run(7'd1);
    wait_tx(b0 + 2, 100);
    stall = 1'b1;
    repeat (3) @(negedge clock);
    check("stall_busy", 32'(bus.busy_o), 1);
    check("stall_data", 32'(bus.tx_data_o), 32'h33);
    reset = 1'b0;
    @(negedge clock);
    check_idle("midreset");
    reset = 1'b1;
    check("midreset_exp_left", exp_q.size(), 2);
    exp_q.delete();
    check("midreset_addr_left", addr_q.size(), 0);
    repeat (15) @(negedge clock);
    stall = 1'b0;
    check("midreset_no_done", done_cnt - d0, 0);
    mem[0] = 32'hA5A6A7A8;
    push_word(32'hA5A6A7A8, 7'd0);
    b0 = n_tx; d0 = done_cnt;
    run(7'd1);
    wait_done(500);
    tally("after_reset", b0, d0, 4);
    // maximum count, storage[i] = i
    for (int i = 0; i < 127; i++) begin
      mem[i] = 32'(i);
      push_word(32'(i), 7'(i));
    end
    b0 = n_tx; d0 = done_cnt; r0 = n_rd;
    run(7'd127);
    wait_done(20000);
    tally("max", b0, d0, 508);
    check("max_reads", n_rd - r0, 127);
    check("max_last_addr", 32'(bus.rd_addr_o), 126);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/mem_dump_tx.md
Name: mem_dump_tx

Overview:
Readback path for the debug link, and the transmit-side counterpart of the UART-to-memory loader.
- Walks a word-addressed storage (instruction memory, register bank or data memory) from address 0 to n_words_i-1.
- Reads each 32-bit word and splits it into 8-bit bytes.
- Hands the bytes one at a time to tx_uart using its tx_start/tx_done_tick handshake.
- Sits between the debug unit (start/done) and the storage read port and tx_uart.

Parameters:
- NB_DATA, 32, width of a stored word.
- N_BITS, 8, UART byte width; NB_DATA must be a multiple of N_BITS.
- NB_ADDR, 7, storage address width.
- BYTES (derived), NB_DATA/N_BITS = 4, bytes per word.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start_i  in  1  begin a dump; sampled only in IDLE.
- n_words_i  in  NB_ADDR  number of words to send; latched on accepted start.
- rd_en_o  out  1  storage read enable.
- rd_addr_o  out  NB_ADDR  storage read address.
- rd_data_i  in  NB_DATA  storage read data; valid exactly 1 cycle after rd_en_o.
- tx_start_o  out  1  one-cycle pulse to tx_uart tx_start.
- tx_data_o  out  N_BITS  byte to tx_uart din.
- tx_done_tick_i  in  1  tx_uart tx_done_tick; byte fully sent.
- busy_o  out  1  high from accepted start until done_o.
- done_o  out  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset (reset==0 at a clock edge) forces all of the following, regardless of state, including mid-byte:
  - state=IDLE
  - rd_en_o=0, rd_addr_o=0
  - tx_start_o=0, tx_data_o=0
  - busy_o=0, done_o=0
  - internal word register=0, byte index=0, word count=0
- Byte order: least-significant byte first (word[7:0], then [15:8], [23:16], [31:24]).
- IDLE:
  - busy_o=0.
  - start_i=1 and n_words_i!=0: latch n_words_i, set addr=0, go to READ.
  - start_i=1 and n_words_i==0: go to FINISH; no read and no tx_start.
- READ: rd_en_o=1 and rd_addr_o=addr for exactly one cycle; go to LATCH.
- LATCH: capture rd_data_i into the word register, set byte index=0; go to SEND.
- SEND: tx_start_o=1 for exactly one cycle; tx_data_o=word[N_BITS-1:0]; go to WAIT.
- WAIT:
  - tx_data_o is held stable and tx_start_o=0.
  - On tx_done_tick_i=1, with byte index < BYTES-1: shift the word right by N_BITS, increment byte index, go to SEND.
  - On tx_done_tick_i=1, with byte index == BYTES-1 and addr == n_words-1: go to FINISH.
  - On tx_done_tick_i=1, with byte index == BYTES-1 otherwise: addr+1, go to READ.
- FINISH: done_o=1 for one cycle, busy_o=0; go to IDLE.
- busy_o=1 in READ, LATCH, SEND and WAIT.
- Latency:
  - start_i sampled at edge k: rd_en_o high in cycle k+1, tx_start_o high in cycle k+3.
  - Byte-to-byte: tx_done_tick at edge j gives the next tx_start_o in cycle j+1.
  - Word-to-word: tx_done_tick at edge j gives the next tx_start_o in cycle j+3.
- Boundaries:
  - start_i while busy is ignored; the latched n_words is not changed.
  - tx_done_tick_i outside WAIT is ignored.
  - n_words_i = 2^NB_ADDR-1 is the maximum and sends addresses 0..126; the address never wraps.
  - A stalled tx_uart (no tick) holds WAIT indefinitely.
  - The word register is updated only in LATCH, so a rd_data_i change after capture has no effect.

Decomposition:
- Shared package holds:
  - state encoding localparams ST_IDLE, ST_READ, ST_LATCH, ST_SEND, ST_WAIT, ST_FINISH.
  - BYTES_PER_WORD = NB_DATA/N_BITS.
  - Byte-index width $clog2(BYTES_PER_WORD); the same constants are reused by the loader side.
- One natural sub-module: word_shift_out.
  - Parallel-load NB_DATA register with a shift-right-by-N_BITS enable.
  - Exposes its low byte and a last-byte flag.
- FSM and address counter stay in mem_dump_tx.

Test Plan:
- Single word: storage[0]=32'hA1B2C3D4, n_words=1, tx model ticks 10 cycles after each start -> bytes D4, C3, B2, A1; exactly 4 tx_start pulses; one done_o; busy_o low after done_o.
- Three words: storage[0..2]=32'h00000001, 32'h12345678, 32'hFFFFFFFF -> byte stream 01,00,00,00,78,56,34,12,FF,FF,FF,FF; rd_addr_o sequence 0,1,2; measured latencies match the Behaviour figures.
- n_words=0 with start_i=1 -> done_o one cycle later; rd_en_o and tx_start_o never asserted.
- start_i pulsed again during word 1 with n_words_i=5 while a 2-word dump runs -> only 8 bytes sent; done_o once.
- reset=0 in WAIT of the second byte -> next edge: state IDLE, all outputs 0; a new start with n_words=1 then sends a clean 4-byte sequence from address 0.
- Max count n_words=127 with storage[i]=i -> 508 bytes; last rd_addr_o=126; no address wrap; single done_o.
